// File: rtl/bitrev_reorder_ctrl.sv
// Loads a block of 2^log_n coefficients in natural order and drains them in
// bit-reversed index order over valid/ready streams.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; no handshakes accepted or offered
//   LOAD  | in_ready high; each input handshake fills mem_q[wr_cnt]
//   DRAIN | out_valid high; presenting mem_q[rev(rd_cnt)] until n words sent
module bitrev_reorder_ctrl #(
    parameter int DATA_W    = 8,
    parameter int LOG_N_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        log_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 1 << LOG_N_MAX;
    localparam int CNT_W = LOG_N_MAX + 1;
    localparam int LN_W  = $clog2(LOG_N_MAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [LN_W-1:0]    ln_q, ln_d;
    logic [CNT_W-1:0]   wr_q, wr_d;
    logic [CNT_W-1:0]   rd_q, rd_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [LN_W-1:0]      ln_clamp;
    logic [CNT_W-1:0]     n_last;
    logic [LOG_N_MAX-1:0] rev_idx;
    logic                 in_hs;
    logic                 out_hs;

    assign ln_clamp = (log_n > 8'(LOG_N_MAX)) ? LN_W'(LOG_N_MAX) : log_n[LN_W-1:0];
    assign n_last   = (CNT_W'(1) << ln_q) - CNT_W'(1);

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Only the low ln_q bits of rd_cnt take part in the reversal.
    always_comb begin
        rev_idx = '0;
        for (int j = 0; j < LOG_N_MAX; j++) begin
            if (j < int'(ln_q)) rev_idx[j] = rd_q[int'(ln_q) - 1 - j];
        end
    end

    assign out_data = (state_q == DRAIN) ? mem_q[rev_idx] : '0;

    always_comb begin
        state_d = state_q;
        ln_d    = ln_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ln_d    = ln_clamp;
                    wr_d    = '0;
                    rd_d    = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_hs) begin
                    wr_d = wr_q + CNT_W'(1);
                    if (wr_q == n_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    rd_d = rd_q + CNT_W'(1);
                    if (rd_q == n_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ln_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ln_q    <= ln_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (in_hs) begin
            mem_q[wr_q[LOG_N_MAX-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
// Directed bench for bitrev_reorder_ctrl: table of whole-block vectors plus
// hand-written reset-abort sequences.
module tb_bitrev_reorder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] log_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    bitrev_reorder_ctrl #(.DATA_W(8), .LOG_N_MAX(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .log_n     (log_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]      ln;
        int              n;
        logic [7:0][7:0] din;
        logic [7:0][7:0] dout;
        bit              toggle;
        bit              poke;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int cnt;
        int guard;
        int t0;
        @(negedge clk);
        start     = 1'b1;
        log_n     = v.ln;
        t0        = cyc;
        out_ready = v.toggle ? 1'b1 : 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d_busy_after_start", id), 32'(busy), 32'd1);
        chk($sformatf("v%0d_in_ready_after_start", id), 32'(in_ready), 32'd1);
        for (int k = 0; k < v.n; k++) begin
            in_valid = 1'b1;
            in_data  = v.din[k];
            if (v.poke && k == 1) begin
                start = 1'b1;
                log_n = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        chk($sformatf("v%0d_out_valid_at_drain", id), 32'(out_valid), 32'd1);
        cnt   = 0;
        guard = 0;
        while (cnt < v.n && guard < 8 * v.n + 8) begin
            out_ready = v.toggle ? ~out_ready : 1'b1;
            if (v.poke) begin
                start = (cnt == 1);
                log_n = 8'd0;
            end
            if (out_valid) begin
                chk($sformatf("v%0d_out_data[%0d]", id, cnt), 32'(out_data), 32'(v.dout[cnt]));
                if (out_ready) cnt++;
            end
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        if (cnt < v.n) chk($sformatf("v%0d_drain_timeout", id), 32'(cnt), 32'(v.n));
        chk($sformatf("v%0d_done_pulse", id), 32'(done), 32'd1);
        chk($sformatf("v%0d_busy_at_done", id), 32'(busy), 32'd0);
        chk($sformatf("v%0d_out_valid_at_done", id), 32'(out_valid), 32'd0);
        if (!v.toggle && !v.poke)
            chk($sformatf("v%0d_start_to_done_edges", id), 32'(cyc - t0), 32'(2 * v.n + 1));
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_done_drops", id), 32'(done), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{ln: 8'd3, n: 8,
                    din:  {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
                    dout: {8'd7, 8'd3, 8'd5, 8'd1, 8'd6, 8'd2, 8'd4, 8'd0},
                    toggle: 1'b0, poke: 1'b0};
        vecs[1] = '{ln: 8'd2, n: 4,
                    din:  {32'h0, 8'd13, 8'd12, 8'd11, 8'd10},
                    dout: {32'h0, 8'd13, 8'd11, 8'd12, 8'd10},
                    toggle: 1'b1, poke: 1'b0};
        vecs[2] = '{ln: 8'd0, n: 1,
                    din:  {56'h0, 8'h5A},
                    dout: {56'h0, 8'h5A},
                    toggle: 1'b0, poke: 1'b0};
        vecs[3] = '{ln: 8'd5, n: 8,
                    din:  {8'd27, 8'd26, 8'd25, 8'd24, 8'd23, 8'd22, 8'd21, 8'd20},
                    dout: {8'd27, 8'd23, 8'd25, 8'd21, 8'd26, 8'd22, 8'd24, 8'd20},
                    toggle: 1'b0, poke: 1'b0};
        vecs[4] = '{ln: 8'd1, n: 2,
                    din:  {48'h0, 8'hA1, 8'hA0},
                    dout: {48'h0, 8'hA1, 8'hA0},
                    toggle: 1'b0, poke: 1'b0};
        vecs[5] = '{ln: 8'd2, n: 4,
                    din:  {32'h0, 8'd4, 8'd3, 8'd2, 8'd1},
                    dout: {32'h0, 8'd4, 8'd2, 8'd3, 8'd1},
                    toggle: 1'b0, poke: 1'b1};

        rst       = 1'b1;
        start     = 1'b0;
        log_n     = 8'd0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Abort mid-LOAD after 3 of 8 words.
        @(negedge clk);
        start = 1'b1;
        log_n = 8'd3;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hE0 + 8'(k);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_load");
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        chk_reset_outputs("rst_load_idle");
        run_vec(vecs[0], 10);

        // Abort mid-DRAIN after 4 of 8 outputs.
        @(negedge clk);
        start = 1'b1;
        log_n = 8'd3;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(k);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rst_drain_o0", 32'(out_data), 32'h40);
        @(negedge clk);
        chk("rst_drain_o1", 32'(out_data), 32'h44);
        @(negedge clk);
        chk("rst_drain_o2", 32'(out_data), 32'h42);
        @(negedge clk);
        chk("rst_drain_o3", 32'(out_data), 32'h46);
        @(negedge clk);
        chk("rst_drain_o4_pending", 32'(out_data), 32'h41);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_drain");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_drain_no_done[%0d]", k), 32'(done), 32'd0);
        end
        run_vec(vecs[3], 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
